uart_text_cursor: RTL and testbench
===================================

Name: uart_text_cursor

Overview:
- Sits between the UART receiver and the 4x32 character RAM write port. It sits directly upstream of the RAM, and the VGA text generator reads that RAM.
- Turns each received byte into at most one RAM write and keeps the text cursor up to date.
- Handles control characters: newline, backspace and form-feed clear.
- Runs a hardware clear sweep after reset and on form feed. Exports the cursor position for the seven-segment display.

Parameters:
- COLS, 32, characters per row; must be a power of two.
- ROWS, 4, text rows; must be a power of two.
- COL_W, 5, log2(COLS).
- ROW_W, 2, log2(ROWS).
- BLANK, 8'h20, byte written by clear and by backspace.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- wr_en  out  1  RAM write enable, registered.
- wr_row  out  ROW_W  RAM write row.
- wr_col  out  COL_W  RAM write column.
- wr_data  out  8  RAM write data.
- cur_row  out  ROW_W  current cursor row.
- cur_col  out  COL_W  current cursor column.
- busy  out  1  high while a clear sweep is running.
- overflow  out  1  sticky; set when a byte is dropped.

Behaviour:
- Reset (synchronous, wins over everything):
  - wr_en=0, wr_row=0, wr_col=0, wr_data=BLANK.
  - cur_row=0, cur_col=0, overflow=0.
  - Pending register empty, FSM enters CLEAR with sweep index 0, busy=1.
- FSM has two states, IDLE and CLEAR.
- IDLE, byte classes. A byte is consumed only in the cycle where rx_valid=1. All outputs update at the following clock edge, so latency is 1 cycle.
  - Printable (0x20..0x7E):
    - wr_en=1, wr_row/wr_col = old cursor, wr_data = byte.
    - Cursor advances: col+1. If col was COLS-1: col=0 and row=(row+1) mod ROWS. No scrolling; row ROWS-1 wraps to row 0.
  - 0x0A or 0x0D (newline):
    - No write.
    - col=0, row=(row+1) mod ROWS.
    - A CR immediately followed by LF gives two row advances; this is intentional.
  - 0x08 (backspace):
    - If col>0: col-1.
    - If col=0 and row>0: row-1, col=COLS-1.
    - In both moving cases: wr_en=1 at the new cursor position with wr_data=BLANK.
    - At (0,0): no move, no write.
  - 0x0C (form feed):
    - No write from the byte itself.
    - Enter CLEAR with index 0; busy=1 from the next cycle.
    - Cursor resets to (0,0) on that same edge.
  - All other bytes, including 0x7F and 0x80-0xFF: ignored, no write, no cursor change.
  - wr_en is high for exactly one cycle per write. When no write occurs, wr_en=0 and wr_row/wr_col/wr_data hold their last values.
- CLEAR state:
  - The sweep index counts 0 to ROWS*COLS-1 (128 cycles).
  - Each cycle: wr_en=1, wr_row = index[high bits], wr_col = index[low COL_W bits], wr_data=BLANK.
  - After the write of index ROWS*COLS-1: next state IDLE, busy=0 on that edge, wr_en=0 the following cycle.
- Pending byte (one-deep, used during CLEAR):
  - An rx_valid arriving while busy=1 is stored in the pending register if it is empty.
  - If pending is already full, the byte is dropped and overflow is set to 1. overflow clears only on reset.
  - In the first IDLE cycle after CLEAR, a full pending register is processed exactly as a newly received byte, and pending empties.
  - If rx_valid also asserts in that same cycle: the pending byte is processed and the new byte is dropped with overflow=1.
  - A 0x0C held in pending starts a fresh clear.
- rx_valid while reset=1 is ignored.
- Reset asserted mid-sweep restarts the sweep at index 0 and discards the pending byte.
- cur_row/cur_col are registers; they reflect the cursor after the edge that processed the byte.

Test Plan:
- Reset, no input: exactly 128 wr_en cycles covering (0,0)..(3,31) in row-major order with data 0x20. busy falls after the 128th write; cursor is (0,0).
- After the clear, send "A","B" (0x41, 0x42): writes (0,0)=0x41 then (0,1)=0x42, each 1 cycle after its strobe; cursor ends at (0,2).
- Send 31 printables, then newline 0x0A, then "C": cursor reaches (0,31); LF gives no write and moves to (1,0); "C" writes (1,0). Separately, 128 printables starting from (0,0) end with the cursor wrapped back to (0,0).
- Backspace: at (1,0), 0x08 writes 0x20 at (0,31) and leaves the cursor at (0,31). At (0,0), 0x08 produces no wr_en and no cursor change.
- Form feed then bytes during the sweep: after 0x0C, send "X" at sweep cycle 10 and "Y" at sweep cycle 20. "Y" is dropped and overflow=1; after the sweep, "X" is written at (0,0) and the cursor is at (0,1).
- Reset pulse at sweep index 60 with a pending byte held: the sweep restarts at 0, the pending byte is lost and overflow=0. Bytes 0x07 and 0xC1 sent in IDLE produce no writes.

Source files
------------

// File: rtl/uart_text_cursor.sv
// uart_text_cursor: turns received UART bytes into character-RAM writes
// and keeps the text cursor up to date.
//
// Printable bytes are written at the cursor, which then advances. LF/CR move
// to the start of the next row, BS blanks the previous cell, and FF starts a
// hardware clear sweep of the whole RAM (this sweep also runs after reset).
// While a sweep runs, one received byte can be held and is processed as soon
// as the sweep ends. Any further byte is dropped and the sticky overflow flag
// is set.
//
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset
//   rx_data   received byte, qualified by rx_valid
//   rx_valid  one-cycle strobe per received byte
//   wr_en     RAM write enable (one cycle per write)
//   wr_row    RAM write row
//   wr_col    RAM write column
//   wr_data   RAM write data
//   cur_row   cursor row
//   cur_col   cursor column
//   busy      high while a clear sweep is running
//   overflow  sticky, set when a byte is dropped
module uart_text_cursor #(
  parameter int unsigned COLS  = 32,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COL_W = 5,
  parameter int unsigned ROW_W = 2,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned IDX_W = ROW_W + COL_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROWS * COLS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_FIRST = 8'h20;
  localparam logic [7:0] CH_LAST  = 8'h7E;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_valid_q, pend_valid_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             wr_en_q, wr_en_d;
  logic [ROW_W-1:0] wr_row_q, wr_row_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [COL_W-1:0] cur_col_q, cur_col_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;

  // Byte selected for processing in IDLE (held byte has priority)
  logic             proc_valid;
  logic [7:0]       proc_byte;

  // Next-state, byte decode and write generation
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    wr_en_d      = 1'b0;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    wr_data_d    = wr_data_q;
    cur_row_d    = cur_row_q;
    cur_col_d    = cur_col_q;
    overflow_d   = overflow_q;
    proc_valid   = 1'b0;
    proc_byte    = 8'h00;

    case (state_q)
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_row_d  = idx_q[IDX_W-1:COL_W];
        wr_col_d  = idx_q[COL_W-1:0];
        wr_data_d = BLANK;
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
        // Hold one byte for after the sweep; anything more is lost
        if (rx_valid) begin
          if (!pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_data_d  = rx_data;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end

      default: begin
        if (pend_valid_q) begin
          proc_valid   = 1'b1;
          proc_byte    = pend_data_q;
          pend_valid_d = 1'b0;
          if (rx_valid) begin
            overflow_d = 1'b1;
          end
        end else if (rx_valid) begin
          proc_valid = 1'b1;
          proc_byte  = rx_data;
        end

        if (proc_valid) begin
          if (proc_byte >= CH_FIRST && proc_byte <= CH_LAST) begin
            wr_en_d   = 1'b1;
            wr_row_d  = cur_row_q;
            wr_col_d  = cur_col_q;
            wr_data_d = proc_byte;
            // Column wraps naturally; bump the row when it does
            cur_col_d = cur_col_q + COL_W'(1);
            if (cur_col_q == COL_LAST) begin
              cur_row_d = cur_row_q + ROW_W'(1);
            end
          end else if (proc_byte == CH_LF || proc_byte == CH_CR) begin
            cur_col_d = '0;
            cur_row_d = cur_row_q + ROW_W'(1);
          end else if (proc_byte == CH_BS) begin
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - COL_W'(1);
              wr_en_d   = 1'b1;
              wr_row_d  = cur_row_q;
              wr_col_d  = cur_col_q - COL_W'(1);
              wr_data_d = BLANK;
            end else if (cur_row_q != '0) begin
              cur_row_d = cur_row_q - ROW_W'(1);
              cur_col_d = COL_LAST;
              wr_en_d   = 1'b1;
              wr_row_d  = cur_row_q - ROW_W'(1);
              wr_col_d  = COL_LAST;
              wr_data_d = BLANK;
            end
          end else if (proc_byte == CH_FF) begin
            state_d   = ST_CLEAR;
            idx_d     = '0;
            cur_row_d = '0;
            cur_col_d = '0;
          end
        end
      end
    endcase

    busy_d = (state_d == ST_CLEAR);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      idx_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= 8'h00;
      wr_en_q      <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_data_q    <= BLANK;
      cur_row_q    <= '0;
      cur_col_q    <= '0;
      busy_q       <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      wr_en_q      <= wr_en_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_data_q    <= wr_data_d;
      cur_row_q    <= cur_row_d;
      cur_col_q    <= cur_col_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_row   = wr_row_q;
  assign wr_col   = wr_col_q;
  assign wr_data  = wr_data_q;
  assign cur_row  = cur_row_q;
  assign cur_col  = cur_col_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_text_cursor.sv
// Testbench for uart_text_cursor: expected RAM writes (position, data and
// the cycle they must appear) are queued as stimulus is issued; a monitor
// pops and compares them whenever wr_en is seen.
module tb_uart_text_cursor;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [4:0] wr_col;
  logic [7:0] wr_data;
  logic [1:0] cur_row;
  logic [4:0] cur_col;
  logic       busy;
  logic       overflow;

  uart_text_cursor dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int row;
    int col;
    int data;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   m_row   = 0;
  int   m_col   = 0;
  int   sweep_end = 0;

  function automatic void check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
  endfunction

  function automatic void push_wr(input int r, input int c, input int d, input int at);
    exp_t e;
    e.row = r; e.col = c; e.data = d; e.cyc = at;
    exp_q.push_back(e);
  endfunction

  function automatic void push_sweep(input int base, input int n);
    for (int i = 0; i < n; i++) push_wr(i / 32, i % 32, 32'h20, base + i);
    sweep_end = base + 127;
  endfunction

  // Monitor: every observed write must match the head of the queue
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      n_total++;
      $display("FAIL missing_write: got no wr_en at cycle %0d, required row %0d col %0d data 0x%02h",
               mon_e.cyc, mon_e.row, mon_e.col, mon_e.data);
    end
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got row %0d col %0d data 0x%02h at cycle %0d, required no write",
                 wr_row, wr_col, wr_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_row", int'(wr_row), mon_e.row);
        check("wr_col", int'(wr_col), mon_e.col);
        check("wr_data", int'(wr_data), mon_e.data);
        check("wr_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Send a byte in IDLE, queueing the write it must cause
  task automatic send(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(m_row, m_col, int'(b), cyc + 1);
      m_col++;
      if (m_col == 32) begin
        m_col = 0;
        m_row = (m_row + 1) % 4;
      end
    end else if (b == 8'h0A || b == 8'h0D) begin
      m_col = 0;
      m_row = (m_row + 1) % 4;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_row, m_col, 32'h20, cyc + 1);
      end else if (m_row > 0) begin
        m_row--;
        m_col = 31;
        push_wr(m_row, m_col, 32'h20, cyc + 1);
      end
    end else if (b == 8'h0C) begin
      push_sweep(cyc + 2, 128);
      m_row = 0;
      m_col = 0;
    end
    strobe(b);
  endtask

  task automatic check_cursor(input int r, input int c);
    check("cur_row", int'(cur_row), r);
    check("cur_col", int'(cur_col), c);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    tick();
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_data", int'(wr_data), 32'h20);
    check("rst_busy", int'(busy), 1);
    check("rst_overflow", int'(overflow), 0);
    check_cursor(0, 0);
    push_sweep(cyc + 1, 128);
    m_row = 0;
    m_col = 0;
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1'b1;
    end
    if (!done) check("busy_timeout", 0, 1);
    else check("busy_fall_cycle", cyc, sweep_end);
    tick();
  endtask

  int c0;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();

    // Power-up sweep, then two printables
    do_reset();
    wait_idle();
    check_cursor(0, 0);
    send(8'h41);
    send(8'h42);
    check_cursor(0, 2);
    tick();

    // Row fill, newline, backspace across rows
    do_reset();
    wait_idle();
    for (int i = 0; i < 31; i++) send(8'(8'h61 + i % 26));
    check_cursor(0, 31);
    send(8'h0A);
    check_cursor(1, 0);
    send(8'h43);
    check_cursor(1, 1);
    send(8'h08);
    check_cursor(1, 0);
    send(8'h08);
    check_cursor(0, 31);

    // Form feed, then backspace at home does nothing
    send(8'h0C);
    check("ff_busy", int'(busy), 1);
    check_cursor(0, 0);
    wait_idle();
    send(8'h08);
    check_cursor(0, 0);
    tick();

    // 128 printables wrap the cursor back to home
    for (int i = 0; i < 128; i++) send(8'(8'h21 + i % 90));
    check_cursor(0, 0);
    tick();

    // Bytes during a sweep: first held, second dropped
    c0 = cyc;
    send(8'h0C);
    while (cyc < c0 + 11) tick();
    strobe(8'h58);
    check("held_no_overflow", int'(overflow), 0);
    while (cyc < c0 + 21) tick();
    strobe(8'h59);
    check("drop_overflow", int'(overflow), 1);
    check("drop_busy", int'(busy), 1);
    push_wr(0, 0, 32'h58, c0 + 130);
    wait_idle();
    m_col = 1;
    check_cursor(0, 1);
    check("overflow_sticky", int'(overflow), 1);
    tick();

    // Reset mid-sweep with a held byte
    c0 = cyc;
    strobe(8'h0C);
    push_sweep(c0 + 2, 60);
    while (cyc < c0 + 6) tick();
    strobe(8'h5A);
    while (cyc < c0 + 61) tick();
    do_reset();
    wait_idle();
    check_cursor(0, 0);
    send(8'h07);
    send(8'hC1);
    check_cursor(0, 0);
    tick();
    tick();
    tick();

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
